// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: four-requester round-robin arbiter whose registered select
// drives a downstream 4:1 mux. A grant is held until the consumer acks, the
// requester withdraws, or the optional timeout forces a release. The next
// winner is chosen in the same cycle, so back-to-back grants have no bubble.
module mux_sel_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_ack,
  output logic [1:0] o_sel,
  output logic [3:0] o_gnt,
  output logic       o_valid,
  output logic       o_timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A zero TIMEOUT disables forced release entirely.
  localparam bit         TIMEOUT_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_LAST = TIMEOUT_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] sel_reg, sel_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       timeout_reg, timeout_next;
  logic [3:0] gnt_reg, gnt_next;

  logic [2:0] idle_pick;
  logic [2:0] rot_pick;
  logic       withdraw;
  logic       expire;

  // Scan req starting at pointer p, wrapping modulo 4; returns {found, index}.
  // Iterating from the far end lets the nearest set bit overwrite the result.
  function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] req);
    logic [2:0] r;
    logic [1:0] c;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      c = p + 2'(i);
      if (req[c]) begin
        r = {1'b1, c};
      end
    end
    return r;
  endfunction

  // Winner from IDLE uses the stored pointer; winner on release uses the
  // rotated pointer, which puts the released channel at lowest priority.
  assign idle_pick = pick(ptr_reg, i_req);
  assign rot_pick  = pick(sel_reg + 2'd1, i_req);
  assign withdraw  = ~i_req[sel_reg];
  assign expire    = TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST);

  // Next-state, pointer, select and counter logic.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (idle_pick[2]) begin
          state_next = GRANT;
          sel_next   = idle_pick[1:0];
          cnt_next   = 8'd0;
        end
      end
      GRANT: begin
        if (i_ack || withdraw || expire) begin
          // Only a pure timeout release is flagged; ack or withdrawal win.
          timeout_next = ~i_ack & ~withdraw;
          ptr_next     = sel_reg + 2'd1;
          if (rot_pick[2]) begin
            sel_next = rot_pick[1:0];
            cnt_next = 8'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-hot grant decode of the next select, registered with the rest.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
      assign gnt_next[gi] = (state_next == GRANT) && (sel_next == 2'(gi));
    end
  endgenerate

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      sel_reg     <= 2'd0;
      cnt_reg     <= 8'd0;
      timeout_reg <= 1'b0;
      gnt_reg     <= 4'd0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
      gnt_reg     <= gnt_next;
    end
  end

  assign o_sel     = sel_reg;
  assign o_gnt     = gnt_reg;
  assign o_valid   = (state_reg == GRANT);
  assign o_timeout = timeout_reg;

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Four-requester round-robin arbiter that drives the 2-bit select of the 4:1 data mux stage directly downstream (`o_sel` → mux `i_sel`). It picks one pending requester, holds the select stable until the consumer acknowledges, then rotates priority. A programmable timeout releases grants the consumer never acknowledges.

## Interface
- `TIMEOUT`, default 8: grant cycles without `i_ack` before forced release. Legal range 0–255; 0 disables the timeout.
- `i_clk`  in  1  rising-edge clock
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_req`  in  4  request per mux channel; bit n = channel n
- `i_ack`  in  1  consumer has taken the current mux output this cycle
- `o_sel`  out  2  select to the mux; registered
- `o_gnt`  out  4  one-hot grant, equals `1 << o_sel` when `o_valid`, else 0; registered
- `o_valid`  out  1  `o_sel` is a live grant; registered
- `o_timeout`  out  1  one-cycle pulse on forced release; registered

## Operation
- State `IDLE` means `o_valid` = 0. State `GRANT` means `o_valid` = 1.
- Priority pointer `ptr` (2 bits) marks the highest-priority channel.
- Winner selection scans `i_req` from `ptr` upward modulo 4. The first set bit wins.
- IDLE → GRANT when any `i_req` bit is set. `o_sel` takes the winner; `ptr` is unchanged.
- GRANT has three release causes, in priority order:
  1. `i_ack` = 1.
  2. `i_req[o_sel]` = 0 (withdrawal).
  3. Timeout expiry.
- On any release:
  - `ptr` ← `o_sel` + 1, wrapping 3 → 0.
  - Re-arbitration uses the new `ptr` and the current-cycle `i_req`. The released channel's own request takes part at lowest priority.
  - If any request is present, stay in GRANT with the new winner (back-to-back, no bubble). Otherwise go to IDLE.
- With no release, GRANT holds. `o_sel` and `o_gnt` must not change.
- In IDLE, `o_sel` holds its last value so the mux output stays stable. `o_gnt` = 0.
- Timeout:
  - Counter `cnt`, width 8, clears to 0 on every new grant, including back-to-back grants.
  - `cnt` increments on each GRANT cycle without release.
  - When `TIMEOUT` ≠ 0 and `cnt` == `TIMEOUT`−1 with no ack and no withdrawal, a timeout release occurs.
  - `o_timeout` = 1 in the following cycle only.
- Ack and timeout in the same cycle: treat as ack, no `o_timeout` pulse.
- Ack when `o_valid` = 0: ignored.

## Timing
- Reset values (asynchronous, immediate on `i_rst_n` low):
  - `o_sel` = 0, `o_gnt` = 0, `o_valid` = 0, `o_timeout` = 0
  - `ptr` = 0, `cnt` = 0, state = IDLE
- Request-to-grant latency: 1 cycle. A request seen at edge k gives `o_valid` = 1 after edge k.
- Ack-to-next-grant latency: 0 bubble cycles. The new `o_sel` appears on the edge that samples `i_ack`.
- Maximum grant hold with timeout enabled is `TIMEOUT` cycles.
- Reset mid-GRANT:
  - Outputs drop to their reset values immediately.
  - After reset deasserts, arbitration restarts from `ptr` = 0 on the first edge with requests.
- All outputs are flop outputs. There is no combinational path from `i_req` or `i_ack` to any output.

## Test plan
- Reset and first grant:
  - Hold `i_rst_n` = 0 with `i_req` = 4'b1111. All outputs must stay 0.
  - Release reset, with `i_ack` = 0 and `TIMEOUT` = 0. After the next edge, expect `o_sel` = 0, `o_gnt` = 4'b0001, `o_valid` = 1.
- Rotation:
  - `i_req` = 4'b1111, pulse `i_ack` once each time a grant appears.
  - Grant sequence must be 0, 1, 2, 3, 0 with no bubble cycles between grants.
- Sparse and wrap:
  - `i_req` = 4'b1001, ack every grant.
  - Sequence must be 0, 3, 0, 3. Channels 1 and 2 are never granted.
- Withdrawal:
  - Grant channel 2 with `i_req` = 4'b0100, then drop to 4'b0000 without ack.
  - On the next edge, expect `o_valid` = 0, `o_sel` holding 2, `o_gnt` = 0, and `o_timeout` = 0.
- Timeout:
  - `TIMEOUT` = 4, `i_req` = 4'b0010, never ack.
  - Expect `o_valid` = 1 for exactly 4 cycles.
  - Then `o_timeout` = 1 for 1 cycle, concurrent with a re-grant of channel 1, since it is the only requester.
  - This pattern repeats every 4 cycles.
- Simultaneous events:
  - `TIMEOUT` = 4, ack asserted on the 4th grant cycle.
  - `o_timeout` must stay 0 and the grant must rotate normally.
  - Assert reset mid-grant: all outputs must go to 0 before the next clock edge.
